ram_delay_line: RTL and testbench
=================================

// Module: ram_delay_line
// PURPOSE
//   Multi-channel, RAM-based shift register (delay line) with a run-time programmable length.
//   The block generates its own circular RAM pointer, so no external address counters are needed.
//   It tracks fill state and flags valid output.
//   Sits in the datapath wherever a 1..DEPTH sample delay of CHANNELS parallel lanes is needed.
// PARAMETERS
//   WIDTH     16   bits per channel
//   CHANNELS  2    parallel lanes packed in one RAM word (word = CHANNELS*WIDTH)
//   DEPTH     512  RAM words = maximum delay; must satisfy DEPTH <= 2**ADDR
//   ADDR      9    RAM address width
//   INIT_LEN  512  delay length after reset; legal range 1..DEPTH
// PORTS
//   CLK            in   1               clock; all logic on posedge
//   reset_n        in   1               synchronous, active-low reset
//   CLK_en         in   1               shift strobe; when low, all state holds
//   shiftin        in   CHANNELS*WIDTH  input sample; lane c = [c*WIDTH +: WIDTH]
//   len            in   ADDR+1          requested delay length
//   len_load       in   1               one-cycle strobe to apply len
//   shiftout       out  CHANNELS*WIDTH  delayed sample (registered)
//   shiftout_valid out  1               shiftout holds real delayed data
//   filled         out  1               LEN samples captured; next shift yields valid data
//   len_err        out  1               sticky: a len_load was rejected
// BEHAVIOUR
//   Reset (reset_n=0 at posedge):
//     len_q=INIT_LEN, ptr=0, fill_cnt=0.
//     shiftout=0, shiftout_valid=0, filled=0, len_err=0.
//     RAM contents are not cleared.
//   Shift (CLK_en=1, len_load=0):
//     - write mem[ptr] <= shiftin.
//     - read the same address with read-before-write: the old word is returned.
//     - ptr <= (ptr==len_q-1) ? 0 : ptr+1.
//   Output rule on a shift edge:
//     - if fill_cnt==len_q: shiftout <= old mem[ptr], shiftout_valid <= 1.
//     - else: shiftout <= 0, shiftout_valid <= 0, fill_cnt <= fill_cnt+1.
//   Delay: after shift number N (N>len_q), shiftout = input of shift N-len_q.
//     Latency is exactly len_q shift strobes; idle cycles do not count.
//   filled = (fill_cnt==len_q); combinational from registers.
//   len_q=1: ptr stays 0; each shift outputs the previous shift's input.
//   CLK_en=0: ptr, fill_cnt, shiftout and shiftout_valid hold; no RAM write.
//   len_load=1 (takes priority over CLK_en; a coincident shift is discarded):
//     - len in 1..DEPTH: len_q<=len, ptr<=0, fill_cnt<=0, shiftout<=0,
//       shiftout_valid<=0. Refill is required.
//     - len==0 or len>DEPTH: len_q and all other state unchanged, len_err<=1.
//   len_err clears only on reset.
//   Reset asserted mid-stream: same as a reset from power-up; the old stream is lost.
//   Lanes are independent bit slices: no arithmetic and no inter-lane mixing.
// TESTING
//   1. Reset, load len=4, shift in 1..10 on lane0 (lane1 = 100+k):
//      shifts 1-4 give shiftout=0, valid=0; filled=1 after shift 4;
//      shifts 5..10 give lane0=1..6, lane1=101..106.
//   2. len=1, shift 7,8,9: valid from 2nd shift, shiftout 7 then 8; CLK_en gaps of 3 cycles change nothing.
//   3. len=DEPTH=512, shift 0..1023:
//      first valid at shift 513 = 0; shift 1024 gives 511; ptr wraps cleanly 511->0.
//   4. Running at len=4, assert len_load (len=3) together with CLK_en:
//      that shift is dropped, valid=0; next 3 shifts give 0; 4th shift gives the first post-load input.
//   5. len_load with len=0, then len=513:
//      len_err=1; delay stays at the old value with valid uninterrupted; reset clears len_err.
//   6. Pull reset_n low for one cycle mid-stream at len=4:
//      all outputs 0 next cycle, len_q back to INIT_LEN, refill needed before valid.

Source files
------------

// File: rtl/ram_delay_line_if.sv
// ---------------------------------------------------------------------------
// ram_delay_line_if
//   Groups the data/control signals of the RAM delay line into one bundle.
//   The producer/consumer side uses the master modport and the delay line
//   itself uses the slave modport.
//
//   Signals (direction as seen from the delay line):
//     CLK_en         in   shift strobe; when low, all state holds
//     shiftin        in   CHANNELS*WIDTH input sample, lane c = [c*WIDTH +: WIDTH]
//     len            in   ADDR+1 bit requested delay length
//     len_load       in   one-cycle strobe that applies len
//     shiftout       out  registered delayed sample
//     shiftout_valid out  shiftout carries real delayed data
//     filled         out  the programmed number of samples has been captured
//     len_err        out  sticky flag: a len_load was rejected
// ---------------------------------------------------------------------------
interface ram_delay_line_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 2,
    parameter int ADDR     = 9
) ();
    logic                      CLK_en;
    logic [CHANNELS*WIDTH-1:0] shiftin;
    logic [ADDR:0]             len;
    logic                      len_load;
    logic [CHANNELS*WIDTH-1:0] shiftout;
    logic                      shiftout_valid;
    logic                      filled;
    logic                      len_err;

    modport master (
        output CLK_en, shiftin, len, len_load,
        input  shiftout, shiftout_valid, filled, len_err
    );

    modport slave (
        input  CLK_en, shiftin, len, len_load,
        output shiftout, shiftout_valid, filled, len_err
    );
endinterface

// File: rtl/ram_delay_line.sv
// ---------------------------------------------------------------------------
// ram_delay_line
//   Multi-channel RAM-based delay line with a run-time programmable length of
//   1..DEPTH shift strobes. A single circular pointer addresses the RAM; each
//   shift reads the old word at the pointer (read-before-write) and overwrites
//   it with the new sample, so the word read back is exactly len_q shifts old.
//   A fill counter suppresses output until len_q samples have been captured.
//
//   Ports:
//     CLK      in  clock, everything on posedge
//     reset_n  in  synchronous active-low reset
//     bus      slave modport of ram_delay_line_if (shift data, length control,
//              delayed output and status flags)
// ---------------------------------------------------------------------------
module ram_delay_line #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 512,
    parameter int ADDR     = 9,
    parameter int INIT_LEN = 512
) (
    input  logic             CLK,
    input  logic             reset_n,
    ram_delay_line_if.slave  bus
);
    localparam int            WORD    = CHANNELS * WIDTH;
    localparam logic [ADDR:0] DEPTH_L = (ADDR+1)'(DEPTH);
    localparam logic [ADDR:0] INIT_L  = (ADDR+1)'(INIT_LEN);

    logic [WORD-1:0] mem [0:DEPTH-1];

    logic [ADDR:0]   len_reg, len_next;
    logic [ADDR:0]   fill_cnt_reg, fill_cnt_next;
    logic [ADDR-1:0] ptr_reg, ptr_next;
    logic            valid_reg, valid_next;
    logic            len_err_reg, len_err_next;

    logic            shift_en;
    logic            load_ok;
    logic            load_bad;
    logic            full;

    // A load strobe always wins; a shift arriving in the same cycle is dropped,
    // whether or not the requested length is accepted.
    assign shift_en = bus.CLK_en && !bus.len_load;
    assign load_ok  = bus.len_load && (bus.len != '0) && (bus.len <= DEPTH_L);
    assign load_bad = bus.len_load && !load_ok;
    assign full     = (fill_cnt_reg == len_reg);

    // -----------------------------------------------------------------------
    // Control next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        len_next      = len_reg;
        fill_cnt_next = fill_cnt_reg;
        ptr_next      = ptr_reg;
        valid_next    = valid_reg;
        len_err_next  = len_err_reg;

        if (load_ok) begin
            len_next      = bus.len;
            fill_cnt_next = '0;
            ptr_next      = '0;
            valid_next    = 1'b0;
        end else if (load_bad) begin
            len_err_next  = 1'b1;
        end else if (shift_en) begin
            // Pointer wraps at the programmed length, not at DEPTH, so the
            // circular window is exactly len_reg words long.
            if ({1'b0, ptr_reg} == len_reg - 1'b1) begin
                ptr_next = '0;
            end else begin
                ptr_next = ptr_reg + 1'b1;
            end
            if (full) begin
                valid_next = 1'b1;
            end else begin
                valid_next    = 1'b0;
                fill_cnt_next = fill_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            len_reg      <= INIT_L;
            fill_cnt_reg <= '0;
            ptr_reg      <= '0;
            valid_reg    <= 1'b0;
            len_err_reg  <= 1'b0;
        end else begin
            len_reg      <= len_next;
            fill_cnt_reg <= fill_cnt_next;
            ptr_reg      <= ptr_next;
            valid_reg    <= valid_next;
            len_err_reg  <= len_err_next;
        end
    end

    // -----------------------------------------------------------------------
    // RAM write port; contents are deliberately not cleared by reset.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (shift_en) begin
            mem[ptr_reg] <= bus.shiftin;
        end
    end

    // -----------------------------------------------------------------------
    // Registered read, one output register per lane. The read returns the word
    // stored before this edge's write. While filling, the register is forced
    // to zero so stale RAM contents never reach the output.
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] lane_out_reg [CHANNELS];

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
            always_ff @(posedge CLK) begin
                if (!reset_n) begin
                    lane_out_reg[gi] <= '0;
                end else if (load_ok) begin
                    lane_out_reg[gi] <= '0;
                end else if (shift_en) begin
                    if (full) begin
                        lane_out_reg[gi] <= mem[ptr_reg][gi*WIDTH +: WIDTH];
                    end else begin
                        lane_out_reg[gi] <= '0;
                    end
                end
            end

            assign bus.shiftout[gi*WIDTH +: WIDTH] = lane_out_reg[gi];
        end
    endgenerate

    assign bus.shiftout_valid = valid_reg;
    assign bus.filled         = full;
    assign bus.len_err        = len_err_reg;

endmodule

// File: tb/tb_ram_delay_line.sv
// ---------------------------------------------------------------------------
// tb_ram_delay_line
//   Self-checking bench for ram_delay_line. The reference is a plain FIFO of
//   the most recent samples: a shift pushes the input, and once more than
//   len samples are held the oldest one pops out as the delayed sample.
// ---------------------------------------------------------------------------
module tb_ram_delay_line;
    localparam int WIDTH    = 16;
    localparam int CHANNELS = 2;
    localparam int DEPTH    = 512;
    localparam int ADDR     = 9;
    localparam int INIT_LEN = 512;
    localparam int WORD     = CHANNELS * WIDTH;

    logic CLK     = 1'b0;
    logic reset_n = 1'b0;

    always #5 CLK = ~CLK;

    ram_delay_line_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .ADDR(ADDR)) bus ();

    ram_delay_line #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH),
        .ADDR(ADDR), .INIT_LEN(INIT_LEN)
    ) dut (
        .CLK     (CLK),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Reference model state
    int              len_m;
    logic [WORD-1:0] hist [$];
    logic [WORD-1:0] m_out;
    logic            m_valid;
    logic            m_err;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    function automatic logic m_filled();
        return (hist.size() == len_m);
    endfunction

    task automatic model_reset();
        len_m   = INIT_LEN;
        hist.delete();
        m_out   = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
    endtask

    // One clock with the given stimulus; the model advances on the same edge.
    task automatic cycle(input logic en, input logic ld, input logic [ADDR:0] ln,
                         input logic [WORD-1:0] d);
        bus.CLK_en   = en;
        bus.len_load = ld;
        bus.len      = ln;
        bus.shiftin  = d;
        @(posedge CLK);
        cyc++;
        if (ld) begin
            if (int'(ln) >= 1 && int'(ln) <= DEPTH) begin
                len_m   = int'(ln);
                hist.delete();
                m_out   = '0;
                m_valid = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end else if (en) begin
            hist.push_back(d);
            if (hist.size() > len_m) begin
                m_out   = hist.pop_front();
                m_valid = 1'b1;
            end else begin
                m_out   = '0;
                m_valid = 1'b0;
            end
        end
        #1;
        bus.CLK_en   = 1'b0;
        bus.len_load = 1'b0;
        $display("cyc %0d en=%b ld=%b len=%0d in=%h -> out=%h v=%b f=%b e=%b",
                 cyc, en, ld, ln, d, bus.shiftout, bus.shiftout_valid,
                 bus.filled, bus.len_err);
    endtask

    task automatic do_reset(input int n);
        bus.CLK_en   = 1'b1;
        bus.len_load = 1'b0;
        bus.shiftin  = WORD'($urandom);
        reset_n      = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
        reset_n    = 1'b1;
        bus.CLK_en = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset(2);
        checks++;
        if (bus.shiftout !== '0 || bus.shiftout_valid !== 1'b0 || bus.filled !== 1'b0 ||
            bus.len_err !== 1'b0) begin
            $display("FAIL reset: got out=%h v=%b f=%b e=%b, want all 0",
                     bus.shiftout, bus.shiftout_valid, bus.filled, bus.len_err);
        end else passes++;
    endtask

    task automatic test_basic();
        cycle(1'b0, 1'b1, 10'd4, '0);
        for (int k = 1; k <= 10; k++) begin
            cycle(1'b1, 1'b0, 10'd0, {16'(100 + k), 16'(k)});
            checks++;
            if (bus.shiftout !== m_out || bus.shiftout_valid !== m_valid ||
                bus.filled !== m_filled() || bus.len_err !== m_err) begin
                $display("FAIL basic k=%0d: got out=%h v=%b f=%b, want out=%h v=%b f=%b",
                         k, bus.shiftout, bus.shiftout_valid, bus.filled,
                         m_out, m_valid, m_filled());
            end else passes++;
            if (k > 4) begin
                checks++;
                if (bus.shiftout !== {16'(100 + k - 4), 16'(k - 4)}) begin
                    $display("FAIL basic_value k=%0d: got %h want %h", k, bus.shiftout,
                             {16'(100 + k - 4), 16'(k - 4)});
                end else passes++;
            end
        end
    endtask

    task automatic test_len1();
        cycle(1'b0, 1'b1, 10'd1, '0);
        for (int k = 7; k <= 9; k++) begin
            cycle(1'b1, 1'b0, 10'd0, WORD'(k));
            for (int g = 0; g < 4; g++) begin
                checks++;
                if (bus.shiftout !== m_out || bus.shiftout_valid !== m_valid ||
                    bus.filled !== m_filled()) begin
                    $display("FAIL len1 k=%0d gap=%0d: got out=%h v=%b f=%b, want out=%h v=%b f=%b",
                             k, g, bus.shiftout, bus.shiftout_valid, bus.filled,
                             m_out, m_valid, m_filled());
                end else passes++;
                if (g < 3) cycle(1'b0, 1'b0, 10'd0, WORD'($urandom));
            end
        end
    endtask

    task automatic test_max();
        cycle(1'b0, 1'b1, 10'(DEPTH), '0);
        for (int i = 0; i < 2 * DEPTH; i++) begin
            cycle(1'b1, 1'b0, 10'd0, {16'($urandom), 16'(i)});
            checks++;
            if (bus.shiftout !== m_out || bus.shiftout_valid !== m_valid ||
                bus.filled !== m_filled()) begin
                $display("FAIL max shift=%0d: got out=%h v=%b f=%b, want out=%h v=%b f=%b",
                         i + 1, bus.shiftout, bus.shiftout_valid, bus.filled,
                         m_out, m_valid, m_filled());
            end else passes++;
            if (i == DEPTH || i == 2 * DEPTH - 1) begin
                checks++;
                if (bus.shiftout[15:0] !== 16'(i - DEPTH) || bus.shiftout_valid !== 1'b1) begin
                    $display("FAIL max_edge shift=%0d: got lane0=%0d v=%b want lane0=%0d v=1",
                             i + 1, bus.shiftout[15:0], bus.shiftout_valid, i - DEPTH);
                end else passes++;
            end
        end
    endtask

    task automatic test_reload();
        logic [WORD-1:0] first_in;
        cycle(1'b0, 1'b1, 10'd4, '0);
        for (int k = 0; k < 6; k++) cycle(1'b1, 1'b0, 10'd0, WORD'($urandom));
        cycle(1'b1, 1'b1, 10'd3, WORD'($urandom));
        checks++;
        if (bus.shiftout !== '0 || bus.shiftout_valid !== 1'b0 || bus.filled !== 1'b0) begin
            $display("FAIL reload_drop: got out=%h v=%b f=%b want 0/0/0",
                     bus.shiftout, bus.shiftout_valid, bus.filled);
        end else passes++;
        first_in = WORD'($urandom);
        for (int k = 1; k <= 4; k++) begin
            cycle(1'b1, 1'b0, 10'd0, (k == 1) ? first_in : WORD'($urandom));
            checks++;
            if (bus.shiftout !== m_out || bus.shiftout_valid !== m_valid ||
                bus.filled !== m_filled()) begin
                $display("FAIL reload k=%0d: got out=%h v=%b f=%b, want out=%h v=%b f=%b",
                         k, bus.shiftout, bus.shiftout_valid, bus.filled,
                         m_out, m_valid, m_filled());
            end else passes++;
        end
        checks++;
        if (bus.shiftout !== first_in || bus.shiftout_valid !== 1'b1) begin
            $display("FAIL reload_first: got %h v=%b want %h v=1",
                     bus.shiftout, bus.shiftout_valid, first_in);
        end else passes++;
    endtask

    task automatic test_bad_len();
        logic [ADDR:0] bad [2];
        bad[0] = 10'd0;
        bad[1] = 10'(DEPTH + 1);
        for (int b = 0; b < 2; b++) begin
            cycle(1'b0, 1'b1, bad[b], '0);
            checks++;
            if (bus.len_err !== 1'b1 || bus.shiftout_valid !== 1'b1 || bus.shiftout !== m_out) begin
                $display("FAIL bad_len len=%0d: got e=%b v=%b out=%h want e=1 v=1 out=%h",
                         bad[b], bus.len_err, bus.shiftout_valid, bus.shiftout, m_out);
            end else passes++;
            for (int k = 0; k < 4; k++) begin
                cycle(1'b1, 1'b0, 10'd0, WORD'($urandom));
                checks++;
                if (bus.shiftout !== m_out || bus.shiftout_valid !== 1'b1 ||
                    bus.len_err !== 1'b1) begin
                    $display("FAIL bad_len_run k=%0d: got out=%h v=%b e=%b want out=%h v=1 e=1",
                             k, bus.shiftout, bus.shiftout_valid, bus.len_err, m_out);
                end else passes++;
            end
        end
        do_reset(1);
        checks++;
        if (bus.len_err !== 1'b0) begin
            $display("FAIL bad_len_clear: got e=%b want 0", bus.len_err);
        end else passes++;
    endtask

    task automatic test_reset_mid();
        cycle(1'b0, 1'b1, 10'd4, '0);
        for (int k = 0; k < 6; k++) cycle(1'b1, 1'b0, 10'd0, WORD'($urandom));
        do_reset(1);
        checks++;
        if (bus.shiftout !== '0 || bus.shiftout_valid !== 1'b0 || bus.filled !== 1'b0) begin
            $display("FAIL reset_mid: got out=%h v=%b f=%b want 0/0/0",
                     bus.shiftout, bus.shiftout_valid, bus.filled);
        end else passes++;
        // Length must be back at INIT_LEN: first valid only at shift INIT_LEN+1.
        for (int k = 1; k <= INIT_LEN + 2; k++) begin
            cycle(1'b1, 1'b0, 10'd0, WORD'($urandom));
            checks++;
            if (bus.shiftout !== m_out || bus.shiftout_valid !== m_valid ||
                bus.filled !== m_filled()) begin
                $display("FAIL reset_refill k=%0d: got out=%h v=%b f=%b, want out=%h v=%b f=%b",
                         k, bus.shiftout, bus.shiftout_valid, bus.filled,
                         m_out, m_valid, m_filled());
            end else passes++;
        end
    endtask

    task automatic test_random();
        logic          en, ld;
        logic [ADDR:0] ln;
        for (int i = 0; i < 1500; i++) begin
            en = ($urandom_range(0, 9) < 7);
            ld = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 5))
                0:       ln = 10'd0;
                1:       ln = 10'($urandom_range(DEPTH + 1, 1023));
                default: ln = 10'($urandom_range(1, 12));
            endcase
            cycle(en, ld, ln, WORD'($urandom));
            checks++;
            if (bus.shiftout !== m_out || bus.shiftout_valid !== m_valid ||
                bus.filled !== m_filled() || bus.len_err !== m_err) begin
                $display("FAIL random i=%0d: got out=%h v=%b f=%b e=%b, want out=%h v=%b f=%b e=%b",
                         i, bus.shiftout, bus.shiftout_valid, bus.filled, bus.len_err,
                         m_out, m_valid, m_filled(), m_err);
            end else passes++;
        end
    endtask

    initial begin
        bus.CLK_en   = 1'b0;
        bus.len_load = 1'b0;
        bus.len      = '0;
        bus.shiftin  = '0;
        model_reset();
        test_reset();
        test_basic();
        test_len1();
        test_max();
        test_reload();
        test_bad_len();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
